sys_mem_arbiter: RTL and testbench

Four-requester arbiter that sits directly upstream of the single-ported system data memory. It serialises accesses from the processor and the three external IPs (E1, E2, E3) onto the memory's one read/write strobe pair. Every strobe is registered and mutually exclusive, so the memory never sees two simultaneous accesses. It keeps fixed priority (processor > E1 > E2 > E3), adds starvation aging, and uses a req/ack handshake with registered read data.

---
 rtl/sysmem_pkg.sv | 23 ++
 rtl/sys_mem_arbiter_starve_pick.sv | 28 ++
 rtl/sys_mem_arbiter.sv | 174 +++++++++++++++++
 tb/tb_sys_mem_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sysmem_pkg.sv
// Shared definitions for the system data memory arbiter: port numbering,
// FSM encoding and a small one-hot helper.
package sysmem_pkg;

    localparam int NPORTS = 4;
    localparam int IDX_W  = $clog2(NPORTS);

    localparam int P_CPU = 0;
    localparam int P_E1  = 1;
    localparam int P_E2  = 2;
    localparam int P_E3  = 3;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } arb_state_t;

    // Isolates the lowest set bit, giving index 0 the highest priority.
    function automatic logic [NPORTS-1:0] lowest_one(input logic [NPORTS-1:0] v);
        return v & (~v + NPORTS'(1));
    endfunction

endpackage

// File: rtl/sys_mem_arbiter_starve_pick.sv
// Combinational winner picker: starved eligible ports beat everyone,
// otherwise plain fixed priority with port 0 first.
module starve_pick
    import sysmem_pkg::*;
(
    input  logic [NPORTS-1:0] elig,
    input  logic [NPORTS-1:0] starved,
    output logic [NPORTS-1:0] grant,
    output logic [IDX_W-1:0]  grant_idx,
    output logic              any_grant
);

    logic [NPORTS-1:0] hungry;
    logic [NPORTS-1:0] pool;

    // Pick the lowest index from the starved set if it is non-empty, else from all eligible ports.
    always_comb begin
        hungry    = elig & starved;
        pool      = (|hungry) ? hungry : elig;
        grant     = lowest_one(pool);
        grant_idx = '0;
        for (int i = NPORTS - 1; i >= 0; i--) begin
            if (grant[i]) grant_idx = IDX_W'(i);
        end
        any_grant = |elig;
    end

endmodule

// File: rtl/sys_mem_arbiter.sv
// Four-requester arbiter in front of the single-ported system data memory.
// Every memory-side output is a flop, so strobes are glitch-free and drop
// immediately on reset.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | strobes low; arbitrate among req & ~ack, latch the winner
//   S_ACCESS | one strobe high for the latched winner; ack next cycle
module sys_mem_arbiter
    import sysmem_pkg::*;
#(
    parameter int N            = 32,
    parameter int AW           = 7,
    parameter int STARVE_LIMIT = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0,
    input  logic         req1,
    input  logic         req2,
    input  logic         req3,
    input  logic         we0,
    input  logic         we1,
    input  logic         we2,
    input  logic         we3,
    input  logic [N-1:0] addr0,
    input  logic [N-1:0] addr1,
    input  logic [N-1:0] addr2,
    input  logic [N-1:0] addr3,
    input  logic [N-1:0] wdata0,
    input  logic [N-1:0] wdata1,
    input  logic [N-1:0] wdata2,
    input  logic [N-1:0] wdata3,
    output logic         ack0,
    output logic         ack1,
    output logic         ack2,
    output logic         ack3,
    output logic [N-1:0] rdata0,
    output logic [N-1:0] rdata1,
    output logic [N-1:0] rdata2,
    output logic [N-1:0] rdata3,
    output logic         mem_read,
    output logic         mem_write,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    input  logic [N-1:0] mem_rdata,
    output logic         busy
);

    localparam int             CW        = $clog2(STARVE_LIMIT) + 1;
    localparam logic [CW-1:0]  CNT_LIMIT = CW'(STARVE_LIMIT);
    localparam logic [CW-1:0]  CNT_MAX   = '1;

    arb_state_t        state_q, state_d;
    logic [NPORTS-1:0] req_v, we_v, ack_q, ack_d, elig, starved, pick_grant;
    logic [IDX_W-1:0]  pick_idx, win_q;
    logic              pick_any, load, rd_d, wr_d;
    logic [N-1:0]      addr_a  [NPORTS];
    logic [N-1:0]      wdata_a [NPORTS];
    logic [N-1:0]      rdata_q [NPORTS];
    logic [CW-1:0]     cnt_q   [NPORTS];

    assign req_v = {req3, req2, req1, req0};
    assign we_v  = {we3, we2, we1, we0};
    assign addr_a[P_CPU]  = addr0;
    assign addr_a[P_E1]   = addr1;
    assign addr_a[P_E2]   = addr2;
    assign addr_a[P_E3]   = addr3;
    assign wdata_a[P_CPU] = wdata0;
    assign wdata_a[P_E1]  = wdata1;
    assign wdata_a[P_E2]  = wdata2;
    assign wdata_a[P_E3]  = wdata3;

    // A port still seeing its ack is masked so it cannot be re-granted on a stale request.
    assign elig = req_v & ~ack_q;

    // A port is starved once it has waited STARVE_LIMIT cycles.
    always_comb begin
        for (int i = 0; i < NPORTS; i++) starved[i] = (cnt_q[i] >= CNT_LIMIT);
    end

    starve_pick u_pick (
        .elig      (elig),
        .starved   (starved),
        .grant     (pick_grant),
        .grant_idx (pick_idx),
        .any_grant (pick_any)
    );

    // Next state, grant load and next strobe/ack values.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        ack_d   = '0;
        case (state_q)
            S_IDLE: begin
                if (pick_any) begin
                    state_d = S_ACCESS;
                    load    = 1'b1;
                end
            end
            S_ACCESS: begin
                state_d = S_IDLE;
                ack_d   = NPORTS'(1) << win_q;
            end
            default: state_d = S_IDLE;
        endcase
        rd_d = load & ~we_v[pick_idx];
        wr_d = load &  we_v[pick_idx];
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Memory-side strobes, latched winner address/data and the ack pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q     <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ack_q     <= '0;
        end else begin
            mem_read  <= rd_d;
            mem_write <= wr_d;
            ack_q     <= ack_d;
            if (load) begin
                win_q     <= pick_idx;
                mem_addr  <= N'(addr_a[pick_idx][AW-1:0]);
                mem_wdata <= wdata_a[pick_idx];
            end
        end
    end

    // Read data lands in the winner's register at the end of the read cycle, alongside its ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NPORTS; i++) rdata_q[i] <= '0;
        end else if (mem_read) begin
            rdata_q[win_q] <= mem_rdata;
        end
    end

    // Saturating wait counters; a port being served or not requesting is not waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NPORTS; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NPORTS; i++) begin
                if (!req_v[i] || (load && pick_grant[i]) ||
                    (state_q == S_ACCESS && win_q == IDX_W'(i))) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] != CNT_MAX) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign ack0   = ack_q[P_CPU];
    assign ack1   = ack_q[P_E1];
    assign ack2   = ack_q[P_E2];
    assign ack3   = ack_q[P_E3];
    assign rdata0 = rdata_q[P_CPU];
    assign rdata1 = rdata_q[P_E1];
    assign rdata2 = rdata_q[P_E2];
    assign rdata3 = rdata_q[P_E3];
    assign busy   = (state_q == S_ACCESS);

endmodule

// File: tb/tb_sys_mem_arbiter.sv
// Bench for sys_mem_arbiter: fixed single-access vectors, hand-written
// multi-cycle sequences and a random phase, all shadowed by a cycle model.
module tb_sys_mem_arbiter;

    localparam int N    = 32;
    localparam int AW   = 7;
    localparam int SL   = 8;
    localparam int CMAX = 15;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   req, we;
    logic [N-1:0] addr_v [4];
    logic [N-1:0] wdata_v [4];
    wire          ack0, ack1, ack2, ack3;
    wire  [N-1:0] rd0, rd1, rd2, rd3;
    wire          mem_read, mem_write, busy;
    wire  [N-1:0] mem_addr, mem_wdata;
    logic [N-1:0] mem_rdata;
    logic [N-1:0] mem [128];
    logic         preload;
    wire  [3:0]   ack;

    always #5 clk = ~clk;

    assign ack = {ack3, ack2, ack1, ack0};

    sys_mem_arbiter #(.N(N), .AW(AW), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req[0]), .req1(req[1]), .req2(req[2]), .req3(req[3]),
        .we0(we[0]), .we1(we[1]), .we2(we[2]), .we3(we[3]),
        .addr0(addr_v[0]), .addr1(addr_v[1]), .addr2(addr_v[2]), .addr3(addr_v[3]),
        .wdata0(wdata_v[0]), .wdata1(wdata_v[1]), .wdata2(wdata_v[2]), .wdata3(wdata_v[3]),
        .ack0(ack0), .ack1(ack1), .ack2(ack2), .ack3(ack3),
        .rdata0(rd0), .rdata1(rd1), .rdata2(rd2), .rdata3(rd3),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    function automatic logic [N-1:0] init_word(input int a);
        if (a == 5) return 32'hDEADBEEF;
        return 32'hA500_0000 ^ (32'(a) * 32'h0001_0101);
    endfunction

    // Memory behind the arbiter: combinational read, write on clock edge.
    assign mem_rdata = mem[mem_addr[AW-1:0]];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 128; i++) mem[i] <= init_word(i);
        end else if (mem_write) begin
            mem[mem_addr[AW-1:0]] <= mem_wdata;
        end
    end

    function automatic logic [N-1:0] rd(input int i);
        case (i)
            0: return rd0;
            1: return rd1;
            2: return rd2;
            default: return rd3;
        endcase
    endfunction

    // Reference model state: what the outputs should be in the current cycle.
    bit           m_busy;
    int           m_port;
    bit           m_we;
    logic [AW-1:0] m_addr;
    logic [N-1:0] m_wdata;
    logic [3:0]   m_ack;
    logic [N-1:0] m_rdata [4];
    int           m_wait [4];
    logic [N-1:0] gold [128];

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_port = 0; m_we = 0; m_addr = '0; m_wdata = '0; m_ack = '0;
        for (int i = 0; i < 4; i++) begin
            m_rdata[i] = '0;
            m_wait[i]  = 0;
        end
    endtask

    // One clock of the arbiter described transaction-wise.
    task automatic model_step();
        logic [3:0] nack;
        int win;
        nack = '0;
        win  = -1;
        if (!m_busy) begin
            for (int i = 0; i < 4; i++)
                if (win < 0 && req[i] && !m_ack[i] && m_wait[i] >= SL) win = i;
            for (int i = 0; i < 4; i++)
                if (win < 0 && req[i] && !m_ack[i]) win = i;
        end
        for (int i = 0; i < 4; i++) begin
            if (!req[i] || i == win || (m_busy && m_port == i)) m_wait[i] = 0;
            else if (m_wait[i] < CMAX) m_wait[i] = m_wait[i] + 1;
        end
        if (m_busy) begin
            nack[m_port] = 1'b1;
            if (m_we) gold[m_addr] = m_wdata;
            else      m_rdata[m_port] = gold[m_addr];
            m_busy = 0;
        end else if (win >= 0) begin
            m_busy  = 1;
            m_port  = win;
            m_we    = we[win];
            m_addr  = addr_v[win][AW-1:0];
            m_wdata = wdata_v[win];
        end
        m_ack = nack;
    endtask

    task automatic check_outputs();
        chk("ack", N'(ack), N'(m_ack));
        chk("mem_read", N'(mem_read), N'(m_busy && !m_we));
        chk("mem_write", N'(mem_write), N'(m_busy && m_we));
        chk("mem_addr", mem_addr, N'(m_addr));
        chk("mem_wdata", mem_wdata, m_wdata);
        chk("busy", N'(busy), N'(m_busy));
        for (int i = 0; i < 4; i++) chk($sformatf("rdata%0d", i), rd(i), m_rdata[i]);
        checks++;
        if (mem_read && mem_write) begin
            errors++;
            $display("FAIL strobe_excl: read=%b write=%b both high (cycle %0d)", mem_read, mem_write, cyc);
        end
    endtask

    // Check this cycle, advance model and DUT by one clock, land 1 time unit after the edge.
    task automatic tick();
        check_outputs();
        if (!rst_n) model_reset();
        else        model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic newreq(input int i);
        we[i]      = 1'($urandom_range(0, 1));
        addr_v[i]  = ($urandom() & 32'hFFFF_FF00) | 32'($urandom_range(0, 15));
        wdata_v[i] = $urandom();
        req[i]     = 1'b1;
    endtask

    typedef struct {
        int           port;
        bit           we;
        logic [N-1:0] addr;
        logic [N-1:0] wdata;
        logic [N-1:0] exp_rdata;
        logic [N-1:0] exp_maddr;
    } vec_t;

    vec_t vec [6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p, t0, a3, a0after, ack1_first, ack1_second, ack2_at;
        int ackc [4];
        int keep [4];
        int rate [4];

        vec[0] = '{2, 1'b0, 32'h0000_0005, 32'h0,          32'hDEADBEEF, 32'h05};
        vec[1] = '{1, 1'b1, 32'h0000_007F, 32'hCAFEF00D,   32'h0,        32'h7F};
        vec[2] = '{0, 1'b0, 32'h0000_007F, 32'h0,          32'hCAFEF00D, 32'h7F};
        vec[3] = '{3, 1'b0, 32'hFFFF_FF85, 32'h0,          32'hDEADBEEF, 32'h05};
        vec[4] = '{2, 1'b1, 32'h0000_0105, 32'h1234_5678,  32'h0,        32'h05};
        vec[5] = '{1, 1'b0, 32'h0000_0005, 32'h0,          32'h1234_5678, 32'h05};
        keep = '{90, 90, 60, 50};
        rate = '{80, 80, 40, 30};

        req = '0;
        we  = '0;
        for (int i = 0; i < 4; i++) begin
            addr_v[i]  = '0;
            wdata_v[i] = '0;
        end
        for (int i = 0; i < 128; i++) gold[i] = init_word(i);
        preload = 1'b1;
        model_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) tick();
        preload = 1'b0;
        rst_n   = 1'b1;

        // Reset values straight after release.
        chk("rst_ack", N'(ack), '0);
        chk("rst_strobes", N'({mem_read, mem_write}), '0);
        chk("rst_mem_addr", mem_addr, '0);
        chk("rst_busy", N'(busy), '0);
        tick();

        // Single uncontended accesses.
        for (int k = 0; k < 6; k++) begin
            p = vec[k].port;
            we[p]      = vec[k].we;
            addr_v[p]  = vec[k].addr;
            wdata_v[p] = vec[k].wdata;
            req[p]     = 1'b1;
            tick();
            chk($sformatf("v%0d_read_c1", k), N'(mem_read), N'(!vec[k].we));
            chk($sformatf("v%0d_write_c1", k), N'(mem_write), N'(vec[k].we));
            chk($sformatf("v%0d_addr_c1", k), mem_addr, vec[k].exp_maddr);
            tick();
            chk($sformatf("v%0d_ack_c2", k), N'(ack), N'(4'b0001 << p));
            chk($sformatf("v%0d_strobes_c2", k), N'({mem_read, mem_write}), '0);
            if (!vec[k].we) chk($sformatf("v%0d_rdata", k), rd(p), vec[k].exp_rdata);
            req[p] = 1'b0;
            tick();
        end

        // All four at once: served 0,1,2,3 two cycles apart.
        we = 4'b0011;
        addr_v[0] = 32'h10; wdata_v[0] = 32'h11;
        addr_v[1] = 32'h11; wdata_v[1] = 32'h22;
        addr_v[2] = 32'h10; wdata_v[2] = 32'h0;
        addr_v[3] = 32'h11; wdata_v[3] = 32'h0;
        req = 4'b1111;
        t0 = cyc;
        ackc = '{-1, -1, -1, -1};
        for (int s = 0; s < 14; s++) begin
            for (int i = 0; i < 4; i++) begin
                if (ack[i] && ackc[i] < 0) begin
                    ackc[i] = cyc - t0;
                    req[i]  = 1'b0;
                end
            end
            tick();
        end
        for (int i = 0; i < 4; i++) chk($sformatf("all4_ack%0d_cycle", i), N'(ackc[i]), N'(2 * i + 2));
        chk("all4_rdata2", rd2, 32'h11);
        chk("all4_rdata3", rd3, 32'h22);

        // Ports 0 and 1 hammer continuously; port 3 must be promoted.
        we = 4'b0011;
        addr_v[0] = 32'h30; wdata_v[0] = 32'h300;
        addr_v[1] = 32'h31; wdata_v[1] = 32'h311;
        addr_v[3] = 32'h30;
        req = 4'b1011;
        t0 = cyc;
        a3 = -1;
        a0after = -1;
        for (int s = 0; s < 30; s++) begin
            if (ack[3] && a3 < 0) begin
                a3 = cyc - t0;
                req[3] = 1'b0;
            end else if (ack[0] && a3 >= 0 && a0after < 0) begin
                a0after = cyc - t0;
            end
            tick();
        end
        req = '0;
        tick();
        tick();
        checks++;
        if (a3 < 0 || a3 > SL + 2) begin
            errors++;
            $display("FAIL starve_port3: ack at cycle %0d, required within %0d", a3, SL + 2);
        end
        checks++;
        if (a3 < 0 || a0after < 0 || a0after - a3 > 4) begin
            errors++;
            $display("FAIL starve_cpu_resume: port0 ack at %0d after port3 ack at %0d", a0after, a3);
        end

        // Write at 0x7F via E1 then read back via CPU.
        we[1] = 1'b1; addr_v[1] = 32'h7F; wdata_v[1] = 32'hCAFEF00D; req[1] = 1'b1;
        tick();
        chk("wr7f_addr_upper", mem_addr & ~32'h7F, '0);
        tick();
        req[1] = 1'b0;
        we[0] = 1'b0; addr_v[0] = 32'hFFFF_FFFF; req[0] = 1'b1;
        tick();
        chk("rd7f_addr", mem_addr, 32'h7F);
        tick();
        chk("rd7f_rdata", rd0, 32'hCAFEF00D);
        req[0] = 1'b0;
        tick();

        // Port 1 re-requests in its ack cycle while port 2 waits.
        we = 4'b0000;
        addr_v[1] = 32'h40;
        addr_v[2] = 32'h41;
        req = 4'b0110;
        t0 = cyc;
        ack1_first = -1; ack1_second = -1; ack2_at = -1;
        for (int s = 0; s < 10; s++) begin
            if (ack[1] && ack1_first < 0) begin
                ack1_first = cyc - t0;
                addr_v[1]  = 32'h42;
            end else if (ack[1] && ack1_second < 0) begin
                ack1_second = cyc - t0;
                req[1] = 1'b0;
            end
            if (ack[2] && ack2_at < 0) begin
                ack2_at = cyc - t0;
                req[2]  = 1'b0;
            end
            tick();
        end
        chk("mask_ack1_first", N'(ack1_first), 32'd2);
        chk("mask_ack2", N'(ack2_at), 32'd4);
        chk("mask_ack1_second", N'(ack1_second), 32'd6);
        chk("mask_rdata1", rd1, init_word(32'h42));

        // Reset in the middle of a write.
        we[0] = 1'b1; addr_v[0] = 32'h20; wdata_v[0] = 32'hAAAA5555; req[0] = 1'b1;
        tick();
        chk("rstmid_write_before", N'(mem_write), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_write_async", N'(mem_write), '0);
        chk("rstmid_busy", N'(busy), '0);
        chk("rstmid_addr", mem_addr, '0);
        model_reset();
        req[0] = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int s = 0; s < 3; s++) tick();
        chk("rstmid_no_ack", N'(ack), '0);
        we[0] = 1'b0; req[0] = 1'b1;
        tick();
        tick();
        chk("rstmid_write_lost", rd0, init_word(32'h20));
        req[0] = 1'b0;
        tick();

        // Random traffic against the model.
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (req[i]) begin
                    if (ack[i]) begin
                        if ($urandom_range(0, 99) < keep[i]) newreq(i);
                        else req[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 99) < rate[i]) begin
                    newreq(i);
                end
            end
            tick();
        end
        req = '0;
        for (int s = 0; s < 4; s++) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
